// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encodings, datapath select codes and flag priority resolution
// shared by the multi-cycle controller and the datapath muxes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        I_NOP, I_JAL, I_JR, I_BEQ, I_LW, I_SW, I_ORI, I_LUI, I_SUBU, I_ADDU
    } instr_e;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JAL = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [1:0] A3_RD = 2'b00;
    localparam logic [1:0] A3_RT = 2'b01;
    localparam logic [1:0] A3_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_DM  = 2'b01;
    localparam logic [1:0] WD_EXT = 2'b10;
    localparam logic [1:0] WD_PC4 = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // Illegal multi-flag decodes collapse to the highest-priority instruction.
    function automatic instr_e resolve(input logic jal, jr, beq, lw, sw, ori, lui, subu, addu);
        return jal  ? I_JAL  :
               jr   ? I_JR   :
               beq  ? I_BEQ  :
               lw   ? I_LW   :
               sw   ? I_SW   :
               ori  ? I_ORI  :
               lui  ? I_LUI  :
               subu ? I_SUBU :
               addu ? I_ADDU : I_NOP;
    endfunction

endpackage

// File: rtl/mc_ctrl_out.sv
// mc_ctrl_out: combinational decode of controller state and resolved instruction
// into datapath write enables and mux/operation selects; en=0 forces all outputs low.
module mc_ctrl_out
    import mc_ctrl_pkg::*;
(
    input  state_e     st,
    input  instr_e     instr,
    input  logic       zero,
    input  logic       ready,
    input  logic       en,
    output logic       PC_WE,
    output logic [1:0] NPC_SEL,
    output logic       IR_WE,
    output logic       GRF_WE,
    output logic [1:0] GRF_A3_MUX,
    output logic [1:0] GRF_WD_MUX,
    output logic       ALU_B_MUX,
    output logic [1:0] ALUOp,
    output logic [1:0] EXTOp,
    output logic       DM_WE,
    output logic       retire
);

    logic       alu_b;
    logic [1:0] alu_op, ext_op;

    assign alu_b  = instr == I_ORI || instr == I_LW || instr == I_SW;
    assign alu_op = {instr == I_ORI, instr == I_SUBU || instr == I_BEQ};
    assign ext_op = {instr == I_LUI, instr == I_LW || instr == I_SW};

    always_comb begin
        PC_WE      = 1'b0;
        NPC_SEL    = NPC_PC4;
        IR_WE      = 1'b0;
        GRF_WE     = 1'b0;
        GRF_A3_MUX = A3_RD;
        GRF_WD_MUX = WD_ALU;
        ALU_B_MUX  = 1'b0;
        ALUOp      = ALU_ADD;
        EXTOp      = EXT_ZERO;
        DM_WE      = 1'b0;
        retire     = 1'b0;
        if (en) begin
            case (st)
                S_FETCH: begin
                    IR_WE = 1'b1;
                    PC_WE = 1'b1;
                end
                S_DECODE: begin
                    PC_WE      = instr == I_JAL || instr == I_JR;
                    NPC_SEL    = instr == I_JAL ? NPC_JAL : instr == I_JR ? NPC_JR : NPC_PC4;
                    GRF_WE     = instr == I_JAL;
                    GRF_A3_MUX = instr == I_JAL ? A3_RA : A3_RD;
                    GRF_WD_MUX = instr == I_JAL ? WD_PC4 : WD_ALU;
                    retire     = instr == I_JAL || instr == I_JR || instr == I_NOP;
                end
                S_EXEC: begin
                    ALU_B_MUX = alu_b;
                    ALUOp     = alu_op;
                    EXTOp     = ext_op;
                    PC_WE     = instr == I_BEQ && zero;
                    NPC_SEL   = instr == I_BEQ ? NPC_BR : NPC_PC4;
                    retire    = instr == I_BEQ;
                end
                S_MEM: begin
                    ALU_B_MUX = alu_b;
                    ALUOp     = alu_op;
                    EXTOp     = ext_op;
                    DM_WE     = instr == I_SW;
                    retire    = instr == I_SW && ready;
                end
                S_WB: begin
                    GRF_WE     = 1'b1;
                    GRF_A3_MUX = (instr == I_ORI || instr == I_LW || instr == I_LUI) ? A3_RT : A3_RD;
                    GRF_WD_MUX = instr == I_LW ? WD_DM : instr == I_LUI ? WD_EXT : WD_ALU;
                    retire     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the P5 MIPS datapath.
// Define MC_CTRL_DM_WAIT_EN to add dm_ready and stall MEM until data memory is ready.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ori,
    input  logic       lw,
    input  logic       sw,
    input  logic       beq,
    input  logic       lui,
    input  logic       jal,
    input  logic       addu,
    input  logic       subu,
    input  logic       jr,
    input  logic       zero,
`ifdef MC_CTRL_DM_WAIT_EN
    input  logic       dm_ready,
`endif
    output logic       PC_WE,
    output logic [1:0] NPC_SEL,
    output logic       IR_WE,
    output logic       GRF_WE,
    output logic [1:0] GRF_A3_MUX,
    output logic [1:0] GRF_WD_MUX,
    output logic       ALU_B_MUX,
    output logic [1:0] ALUOp,
    output logic [1:0] EXTOp,
    output logic       DM_WE,
    output logic       retire,
    output logic [2:0] state
);

    state_e cur, nxt;
    instr_e instr;
    logic   ready;

`ifdef MC_CTRL_DM_WAIT_EN
    assign ready = dm_ready;
`else
    assign ready = 1'b1;
`endif

    assign instr = resolve(jal, jr, beq, lw, sw, ori, lui, subu, addu);
    assign state = cur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur <= S_FETCH;
        else        cur <= nxt;
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: nxt = (instr == I_JAL || instr == I_JR || instr == I_NOP) ? S_FETCH : S_EXEC;
            S_EXEC:   nxt = instr == I_BEQ ? S_FETCH : (instr == I_LW || instr == I_SW) ? S_MEM : S_WB;
            S_MEM:    nxt = !ready ? S_MEM : instr == I_LW ? S_WB : S_FETCH;
            default:  nxt = S_FETCH;
        endcase
    end

    // Reset gates the decode directly so enables drop in the same cycle reset asserts.
    mc_ctrl_out u_out (
        .st         (cur),
        .instr      (instr),
        .zero       (zero),
        .ready      (ready),
        .en         (reset),
        .PC_WE      (PC_WE),
        .NPC_SEL    (NPC_SEL),
        .IR_WE      (IR_WE),
        .GRF_WE     (GRF_WE),
        .GRF_A3_MUX (GRF_A3_MUX),
        .GRF_WD_MUX (GRF_WD_MUX),
        .ALU_B_MUX  (ALU_B_MUX),
        .ALUOp      (ALUOp),
        .EXTOp      (EXTOp),
        .DM_WE      (DM_WE),
        .retire     (retire)
    );

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the P5 MIPS datapath. Consumes the one-hot instruction flags produced by the instruction decoder and sequences the shared datapath through FETCH/DECODE/EXEC/MEM/WB. It drives every register, memory and PC write enable, along with the mux and operation selects that the single-cycle control unit drives combinationally. It sits between the IR decoder and the datapath; it is the only source of write enables in the core.

## Interface
- No parameters.
- `clk` in 1: core clock, rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `ori, lw, sw, beq, lui, jal, addu, subu, jr` in 1 each: one-hot decode of the current IR, valid from DECODE onward.
- `zero` in 1: ALU equal flag, sampled in EXEC.
- `dm_ready` in 1: data-memory ready. Present only with `MC_CTRL_DM_WAIT_EN`.
- `PC_WE` out 1: PC register write.
- `NPC_SEL` out 2: 00 PC+4, 01 branch target, 10 jal target, 11 GPR[rs].
- `IR_WE` out 1: instruction register write.
- `GRF_WE` out 1; `GRF_A3_MUX` out 2 (00 rd, 01 rt, 10 $31); `GRF_WD_MUX` out 2 (00 ALU, 01 DM, 10 EXT, 11 PC+4).
- `ALU_B_MUX` out 1 (0 GPR[rt], 1 EXT); `ALUOp` out 2 (00 add, 01 sub, 10 or); `EXTOp` out 2 (00 zero, 01 sign, 10 lui).
- `DM_WE` out 1.
- `retire` out 1: one-cycle pulse in the last cycle of each instruction.
- `state` out 3: current state, for debug.

## Operation
- States, 3-bit encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5–7 are illegal and return to FETCH on the next edge.
- FETCH: IR_WE=1, PC_WE=1, NPC_SEL=00. Next state: DECODE.
- DECODE:
  - jal: GRF_WE=1, A3=10, WD=11, PC_WE=1, NPC_SEL=10, retire. Next: FETCH.
  - jr: PC_WE=1, NPC_SEL=11, retire. Next: FETCH.
  - No flag set: retire as a nop. Next: FETCH.
  - Otherwise: next state EXEC.
- EXEC:
  - ALU selects follow the single-cycle encoding: ALUOp[0]=subu|beq, ALUOp[1]=ori; ALU_B_MUX=ori|lw|sw; EXTOp[0]=lw|sw, EXTOp[1]=lui.
  - beq: PC_WE=zero, NPC_SEL=01, retire. Next: FETCH.
  - lw, sw: next state MEM.
  - Others: next state WB.
- MEM: ALU/EXT selects are held.
  - sw: DM_WE=1, retire. Next: FETCH.
  - lw: next state WB.
- WB: GRF_WE=1.
  - A3: 01 for ori/lw/lui, else 00.
  - WD: 01 for lw, 10 for lui, else 00.
  - retire. Next: FETCH.
- Multiple flags asserted is illegal. Priority is jal > jr > beq > lw > sw > ori > lui > subu > addu.
- Every enable and select not listed for a state is 0.

## Timing
- Outputs are combinational from `state` and the flags (Moore per state). The state register is the only flop besides the optional wait logic.
- Cycles per instruction:
  - jal, jr, nop: 2.
  - beq: 3.
  - addu, subu, ori, lui, sw: 4.
  - lw: 5.
  - Each dm_ready-low cycle in MEM adds 1 (macro only).
- While `reset`=0: state=FETCH, and all `*_WE`, `retire` and selects are forced 0.
- First FETCH enables assert in the first cycle after `reset` rises.
- Reset mid-instruction aborts immediately. No partial writes occur after reset is asserted.

## Configuration
- `MC_CTRL_DM_WAIT_EN` defined:
  - `dm_ready` port exists. MEM holds while dm_ready=0.
  - sw holds DM_WE=1 every MEM cycle and advances (with retire) only on a dm_ready=1 cycle.
  - lw advances to WB on dm_ready=1.
- Undefined: no `dm_ready` port; MEM is always exactly one cycle.

## Structure
- `mc_ctrl_pkg`: state encodings; NPC_SEL, A3, WD, ALUOp and EXTOp code constants. These are shared with the datapath muxes.
- Sub-module `mc_ctrl_out`: purely combinational state+flags → output decode. The `mc_ctrl` top holds the state register and next-state logic.

## Test plan
- Reset: hold reset=0 for 3 cycles with lw=1 → all WE=0, state=0. Release → cycle 1 IR_WE=1, PC_WE=1.
- addu (then subu, ori, lui): 4 cycles; GRF_WE only in WB. lui → WD=10, A3=01, EXTOp=10. subu → ALUOp=01.
- lw/sw: lw 5 cycles, WD=01 in WB. sw DM_WE=1 only in MEM, GRF_WE never set. With the macro, dm_ready low 2 cycles → sw takes 6 cycles, DM_WE high for 3.
- beq with zero=1 → PC_WE=1 with NPC_SEL=01 in EXEC. zero=0 → PC_WE=0. Both take 3 cycles, with retire in EXEC.
- jal/jr: jal in DECODE → GRF_WE=1, A3=10, WD=11, NPC_SEL=10. jr → NPC_SEL=11, no GRF_WE. Both 2 cycles.
- No flags → 2-cycle nop, retire in DECODE. Assert reset during MEM of sw → DM_WE drops the same cycle, state=0.
